seq_ctrl: RTL

//  Instruction-cycle sequencer for the 5-bit-address accumulator CPU. Drives the

---
 rtl/seq_ctrl_if.sv | 29 ++
 rtl/seq_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/seq_ctrl_if.sv
// seq_ctrl_if: sequencer control/status bundle between seq_ctrl (master) and the datapath/memory (slave).
interface seq_ctrl_if #(parameter int AW = 5, parameter int DW = 8);
  logic          run;
  logic [AW-1:0] pc;
  logic          acc_zero;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          pc_inc;
  logic          pc_load;
  logic [AW-1:0] pc_target;
  logic [AW-1:0] mem_addr;
  logic          rmem;
  logic          wmem;
  logic [DW-1:0] ir;
  logic [DW-1:0] opnd;
  logic          acc_load;
  logic [1:0]    alu_op;
  logic          busy;
  logic          halted;
  logic          fault;
  modport master (
    input  run, pc, acc_zero, mem_ready, mem_rdata,
    output pc_inc, pc_load, pc_target, mem_addr, rmem, wmem, ir, opnd, acc_load, alu_op, busy, halted, fault
  );
  modport slave (
    output run, pc, acc_zero, mem_ready, mem_rdata,
    input  pc_inc, pc_load, pc_target, mem_addr, rmem, wmem, ir, opnd, acc_load, alu_op, busy, halted, fault
  );
endinterface

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle FETCH/DECODE/MEM/WB sequencer for the accumulator CPU, with a mem_ready wait-state timeout.
module seq_ctrl #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 15
) (
  input logic        clock,
  input logic        reset,
  seq_ctrl_if.master bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [2:0] OP_HALT  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_JMP   = 3'd5;
  localparam logic [2:0] OP_JZ    = 3'd6;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_MEM, S_WB, S_HALT, S_FAULT} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] opnd_q, opnd_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [2:0]    op;
  logic          is_store, needs_mem, jump, waiting, timeout;
  assign op        = ir_q[DW-1:AW];
  assign is_store  = op == OP_STORE;
  assign needs_mem = op inside {OP_LOAD, OP_STORE, OP_ADD, OP_SUB};
  assign jump      = op == OP_JMP || (op == OP_JZ && bus.acc_zero);
  assign waiting   = state_q inside {S_FETCH, S_MEM};
  // mem_ready in the last allowed cycle still wins over the timeout
  assign timeout   = waiting && !bus.mem_ready && wait_q == CW'(MAX_WAIT);
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    wait_d  = (waiting && !bus.mem_ready) ? wait_q + 1'b1 : '0;
    case (state_q)
      S_IDLE:   state_d = bus.run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (bus.mem_ready) begin
          ir_d    = bus.mem_rdata;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = op == OP_HALT ? S_HALT : needs_mem ? S_MEM : S_FETCH;
      S_MEM: begin
        if (bus.mem_ready) begin
          opnd_d  = is_store ? opnd_q : bus.mem_rdata;
          state_d = is_store ? S_FETCH : S_WB;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = bus.run ? S_FETCH : S_HALT;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      opnd_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      opnd_q  <= opnd_d;
      wait_q  <= wait_d;
    end
  end
  // Moore decode from flops; only the JZ choice looks at acc_zero
  assign bus.pc_inc    = state_q == S_DECODE && !jump;
  assign bus.pc_load   = state_q == S_DECODE && jump;
  assign bus.pc_target = ir_q[AW-1:0];
  assign bus.mem_addr  = state_q == S_FETCH ? bus.pc : state_q == S_MEM ? ir_q[AW-1:0] : '0;
  assign bus.rmem      = state_q == S_FETCH || (state_q == S_MEM && !is_store);
  assign bus.wmem      = state_q == S_MEM && is_store;
  assign bus.ir        = ir_q;
  assign bus.opnd      = opnd_q;
  assign bus.acc_load  = state_q == S_WB;
  assign bus.alu_op    = state_q != S_WB ? 2'b00 : op == OP_ADD ? 2'b01 : op == OP_SUB ? 2'b10 : 2'b00;
  assign bus.busy      = !(state_q inside {S_IDLE, S_HALT, S_FAULT});
  assign bus.halted    = state_q == S_HALT;
  assign bus.fault     = state_q == S_FAULT;
endmodule
